// File: rtl/csa_accumulator_pipe.sv
`default_nettype none
// ============================================================================
// Module      : csa_accumulator_pipe
// Description : Multi-operand accumulator. Operands are folded into a
//               carry-save (sum, carry) pair with one 3:2 level per beat; at
//               packet end the pair is resolved by a 4-bit CLA slice, one
//               nibble per cycle. Valid/ready on both input and output sides.
// Revision    : 1.0 - initial release
// ============================================================================
module csa_accumulator_pipe #(
   parameter int WIDTH   = 8,
   parameter int MAX_OPS = 16,
   // Derived widths; exposed only so they can appear in the port list.
   localparam int OUT_W  = ((WIDTH + $clog2(MAX_OPS) + 3) / 4) * 4,
   localparam int CNT_W  = $clog2(MAX_OPS + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_sum,
   output logic [CNT_W-1:0] out_count,
   output logic             out_overflow,
   output logic             busy
);

   localparam int NSLICE = OUT_W / 4;
   localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

   localparam logic [CNT_W-1:0] C_MAX_CNT  = CNT_W'(MAX_OPS);
   localparam logic [KW-1:0]    C_LAST_SLC = KW'(NSLICE - 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ACCUM   = 2'd1,
      ST_RESOLVE = 2'd2,
      ST_OUTPUT  = 2'd3
   } state_t;

   state_t           state_q;
   logic [OUT_W-1:0] s_q;
   logic [OUT_W-1:0] c_q;
   logic [OUT_W-1:0] res_q;
   logic [CNT_W-1:0] cnt_q;
   logic             ovf_q;
   logic [KW-1:0]    k_q;
   logic             sc_q;
   logic             in_ready_q;
   logic             out_valid_q;
   logic             busy_q;
   logic [OUT_W-1:0] out_sum_q;
   logic [CNT_W-1:0] out_count_q;
   logic             out_ovf_q;

   logic             w_accept;
   logic [OUT_W-1:0] w_x;
   logic [OUT_W-1:0] w_s_d;
   logic [OUT_W-1:0] w_c_d;
   logic [3:0]       w_a;
   logic [3:0]       w_b;
   logic [3:0]       w_g;
   logic [3:0]       w_p;
   logic [4:0]       w_cy;
   logic [3:0]       w_nib;
   logic [OUT_W-1:0] w_res_d;

   // in_ready is registered and only ever high in IDLE/ACCUM; clear blocks the
   // acceptance through the priority in the state register block.
   assign w_accept = in_valid && in_ready_q;

   // One 3:2 compression level: new operand folded into the carry-save pair.
   always_comb begin
      w_x   = OUT_W'(in_data);
      w_s_d = s_q ^ c_q ^ w_x;
      w_c_d = ((s_q & c_q) | (s_q & w_x) | (c_q & w_x)) << 1;
   end

   // Select nibble k of the sum and carry words for the current resolve cycle.
   always_comb begin
      w_a = 4'd0;
      w_b = 4'd0;
      for (int i = 0; i < NSLICE; i++) begin
         if (k_q == KW'(i)) begin
            w_a = s_q[i*4 +: 4];
            w_b = c_q[i*4 +: 4];
         end
      end
   end

   // 4-bit carry-lookahead slice; carry-in is the registered carry of the
   // previous nibble (zeroed on entry to RESOLVE).
   always_comb begin
      w_g     = w_a & w_b;
      w_p     = w_a ^ w_b;
      w_cy[0] = sc_q;
      w_cy[1] = w_g[0] | (w_p[0] & sc_q);
      w_cy[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & sc_q);
      w_cy[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
              | (w_p[2] & w_p[1] & w_p[0] & sc_q);
      w_cy[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
              | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
              | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & sc_q);
      w_nib   = w_p ^ w_cy[3:0];
   end

   // Merge the freshly resolved nibble into the result word.
   always_comb begin
      w_res_d = res_q;
      for (int i = 0; i < NSLICE; i++) begin
         if (k_q == KW'(i)) begin
            w_res_d[i*4 +: 4] = w_nib;
         end
      end
   end

   // Control FSM with datapath registers and registered outputs. Clear and
   // the output handshake both return everything to the reset values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         s_q         <= '0;
         c_q         <= '0;
         res_q       <= '0;
         cnt_q       <= '0;
         ovf_q       <= 1'b0;
         k_q         <= '0;
         sc_q        <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         out_sum_q   <= '0;
         out_count_q <= '0;
         out_ovf_q   <= 1'b0;
      end else if (clear || (state_q == ST_OUTPUT && out_ready)) begin
         state_q     <= ST_IDLE;
         s_q         <= '0;
         c_q         <= '0;
         res_q       <= '0;
         cnt_q       <= '0;
         ovf_q       <= 1'b0;
         k_q         <= '0;
         sc_q        <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         out_sum_q   <= '0;
         out_count_q <= '0;
         out_ovf_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE, ST_ACCUM: begin
               if (w_accept) begin
                  s_q    <= w_s_d;
                  c_q    <= w_c_d;
                  busy_q <= 1'b1;
                  if (cnt_q == C_MAX_CNT) begin
                     ovf_q <= 1'b1;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
                  if (in_last) begin
                     state_q    <= ST_RESOLVE;
                     in_ready_q <= 1'b0;
                     k_q        <= '0;
                     sc_q       <= 1'b0;
                  end else begin
                     state_q    <= ST_ACCUM;
                  end
               end
            end
            ST_RESOLVE: begin
               res_q <= w_res_d;
               sc_q  <= w_cy[4];
               k_q   <= k_q + 1'b1;
               if (k_q == C_LAST_SLC) begin
                  state_q     <= ST_OUTPUT;
                  out_valid_q <= 1'b1;
                  out_sum_q   <= w_res_d;
                  out_count_q <= cnt_q;
                  out_ovf_q   <= ovf_q;
               end
            end
            default: begin
               // OUTPUT: hold everything until the handshake above fires.
            end
         endcase
      end
   end

   assign in_ready     = in_ready_q;
   assign out_valid    = out_valid_q;
   assign busy         = busy_q;
   assign out_sum      = out_sum_q;
   assign out_count    = out_count_q;
   assign out_overflow = out_ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_csa_accumulator_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_csa_accumulator_pipe
// Description : Scoreboard bench for csa_accumulator_pipe. A driver issues
//               directed and random packets and queues expected results from
//               an arithmetic model; a monitor checks every presented result.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_csa_accumulator_pipe;

   localparam int OUT_W = 12;
   localparam int CNT_W = 5;
   localparam int LAT   = 3;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             clear = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [7:0]       in_data = 8'd0;
   logic             in_last = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [OUT_W-1:0] out_sum;
   logic [CNT_W-1:0] out_count;
   logic             out_overflow;
   logic             busy;

   typedef struct {
      int sum;
      int cnt;
      int ovf;
      int cyc;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   cyc      = 0;
   int   rdy_mode = 0;   // 0 random, 1 forced low, 2 forced high
   int   mdl_sum  = 0;
   int   mdl_n    = 0;
   bit   prev_valid = 1'b0;

   csa_accumulator_pipe dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .clear        (clear),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .in_last      (in_last),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_sum      (out_sum),
      .out_count    (out_count),
      .out_overflow (out_overflow),
      .busy         (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, req, cyc);
   endtask

   task automatic fail_now(input string nm);
      n_checks++;
      $display("FAIL %s: timed out (cycle %0d)", nm, cyc);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Offer one beat until accepted; model updated on acceptance.
   task automatic send_beat(input logic [7:0] x, input logic last);
      bit   done = 1'b0;
      int   waited = 0;
      exp_t e;
      in_valid = 1'b1;
      in_data  = x;
      in_last  = last;
      while (!done) begin
         @(negedge clk);
         if (in_ready) begin
            step();
            done = 1'b1;
            mdl_sum += int'(x);
            mdl_n++;
            if (last) begin
               e.sum = mdl_sum % 4096;
               e.cnt = (mdl_n > 16) ? 16 : mdl_n;
               e.ovf = (mdl_n > 16) ? 1 : 0;
               e.cyc = cyc + LAT;
               exp_q.push_back(e);
               mdl_sum = 0;
               mdl_n   = 0;
            end
         end else begin
            step();
            waited++;
            if (waited > 200) begin
               fail_now("in_ready_wait");
               done = 1'b1;
            end
         end
      end
      in_valid = 1'b0;
      in_last  = 1'($urandom);
      in_data  = 8'($urandom);
   endtask

   task automatic send_const(input logic [7:0] x, input int n);
      for (int i = 0; i < n; i++) send_beat(x, (i == n - 1));
   endtask

   task automatic drain();
      int w = 0;
      while (exp_q.size() != 0 && w < 400) begin
         step();
         w++;
      end
      if (exp_q.size() != 0) fail_now("drain");
      while (exp_q.size() != 0) void'(exp_q.pop_front());
   endtask

   // out_ready generator
   initial begin
      forever begin
         @(posedge clk);
         #1;
         out_ready = (rdy_mode == 0) ? ($urandom_range(0, 3) != 0) : (rdy_mode == 2);
      end
   end

   // Monitor: compares every presented result against the queue head.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (out_valid) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_out_valid", 32'(out_valid), 32'd0);
               end else begin
                  if (!prev_valid) chk("latency", 32'(cyc), 32'(exp_q[0].cyc));
                  chk("out_sum", 32'(out_sum), 32'(exp_q[0].sum));
                  chk("out_count", 32'(out_count), 32'(exp_q[0].cnt));
                  chk("out_overflow", 32'(out_overflow), 32'(exp_q[0].ovf));
                  chk("in_ready_in_output", 32'(in_ready), 32'd0);
                  chk("busy_in_output", 32'(busy), 32'd1);
                  if (out_ready) void'(exp_q.pop_front());
               end
            end else begin
               chk("outputs_zero_when_idle", {19'd0, out_sum, out_count, out_overflow}, 32'd0);
            end
         end
         prev_valid = out_valid;
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int wcnt;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_in_ready", 32'(in_ready), 32'd1);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_out_valid", 32'(out_valid), 32'd0);
      chk("reset_outputs", {19'd0, out_sum, out_count, out_overflow}, 32'd0);
      rst_n = 1'b1;
      step();

      // Basic three-operand packet, single operand, back-to-back packet
      send_const(8'hFF, 3);
      send_beat(8'h5A, 1'b1);
      send_beat(8'h01, 1'b0);
      send_beat(8'h02, 1'b1);
      // Saturation boundary: exactly MAX_OPS and one beyond
      send_const(8'hFF, 16);
      send_const(8'hFF, 17);
      drain();

      // Consumer back-pressure with in_valid asserted during OUTPUT
      rdy_mode = 1;
      step();
      send_beat(8'h3C, 1'b0);
      send_beat(8'hC3, 1'b1);
      wcnt = 0;
      while (!out_valid && wcnt < 50) begin
         step();
         wcnt++;
      end
      if (!out_valid) fail_now("hold_wait_valid");
      in_valid = 1'b1;
      in_data  = 8'h99;
      in_last  = 1'b1;
      repeat (5) step();
      in_valid = 1'b0;
      in_last  = 1'b0;
      rdy_mode = 2;
      wcnt = 0;
      while (out_valid && wcnt < 50) begin
         step();
         wcnt++;
      end
      if (out_valid) fail_now("hold_wait_release");
      chk("post_handshake_busy", 32'(busy), 32'd0);
      chk("post_handshake_in_ready", 32'(in_ready), 32'd1);
      rdy_mode = 0;

      // Clear during ACCUM with an operand presented in the same cycle
      send_beat(8'h10, 1'b0);
      send_beat(8'h20, 1'b0);
      in_valid = 1'b1;
      in_data  = 8'h33;
      in_last  = 1'b1;
      clear    = 1'b1;
      step();
      clear    = 1'b0;
      in_valid = 1'b0;
      in_last  = 1'b0;
      mdl_sum  = 0;
      mdl_n    = 0;
      chk("clear_busy", 32'(busy), 32'd0);
      chk("clear_in_ready", 32'(in_ready), 32'd1);
      send_beat(8'h07, 1'b1);
      drain();

      // Asynchronous reset while resolving slice 1
      send_beat(8'h44, 1'b0);
      send_beat(8'h55, 1'b1);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("async_rst_busy", 32'(busy), 32'd0);
      chk("async_rst_in_ready", 32'(in_ready), 32'd1);
      chk("async_rst_outputs", {18'd0, out_valid, out_sum, out_count, out_overflow}, 32'd0);
      void'(exp_q.pop_back());
      @(negedge clk);
      rst_n = 1'b1;
      step();
      send_beat(8'h80, 1'b0);
      send_beat(8'h80, 1'b1);
      drain();

      // Random packets with idle gaps and random consumer readiness
      for (int p = 0; p < 30; p++) begin
         int n;
         n = $urandom_range(1, 20);
         for (int b = 0; b < n; b++) begin
            repeat ($urandom_range(0, 2)) step();
            send_beat(8'($urandom), (b == n - 1));
         end
      end
      drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/csa_accumulator_pipe.md
Name: csa_accumulator_pipe

Overview:
Multi-operand accumulator that sums a packet of up to MAX_OPS unsigned WIDTH-bit operands, one per accepted beat. Running totals are kept in redundant carry-save form (sum and carry registers), so each operand costs one 3:2 compression level and no carry propagation. When the packet ends, the pair is resolved by a 4-bit carry-lookahead slice, one nibble per cycle. The block sits between an operand stream source and a result consumer, with valid/ready on both sides.

Parameters:
WIDTH, 8, operand width in bits (>=1)
MAX_OPS, 16, operand count per packet guaranteed not to overflow (>=2)
OUT_W (local), WIDTH+$clog2(MAX_OPS) rounded up to a multiple of 4; 12 for defaults
CNT_W (local), $clog2(MAX_OPS+1); 5 for defaults
NSLICE (local), OUT_W/4; 3 for defaults

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
clear  in  1  synchronous abort; returns to IDLE and discards the packet
in_valid  in  1  operand valid
in_ready  out  1  block can accept an operand
in_data  in  WIDTH  unsigned operand
in_last  in  1  marks the final operand of the packet
out_valid  out  1  result valid
out_ready  in  1  consumer accepts the result
out_sum  out  OUT_W  resolved sum, modulo 2^OUT_W
out_count  out  CNT_W  operands accepted, saturating at MAX_OPS
out_overflow  out  1  more than MAX_OPS operands were accepted in this packet
busy  out  1  high in any state other than IDLE

Behaviour:
- States: IDLE, ACCUM, RESOLVE, OUTPUT. On reset: IDLE, all registers 0, in_ready=1, out_valid=0, out_sum=0, out_count=0, out_overflow=0, busy=0.
- in_ready=1 only in IDLE and ACCUM. An operand is accepted on a clock edge where in_valid && in_ready && !clear.
- Accepted operand x is zero-extended to OUT_W, then: S' = S^C^x; C' = (maj(S,C,x) << 1) truncated to OUT_W. Bits carried out of OUT_W are discarded, so the result wraps modulo 2^OUT_W.
- Each acceptance increments the count, which saturates at MAX_OPS. The overflow flag becomes sticky-1 when an operand is accepted while the count already equals MAX_OPS.
- Transitions on acceptance: IDLE->ACCUM, or IDLE->RESOLVE if in_last=1; ACCUM stays ACCUM, or ->RESOLVE if in_last=1.
- RESOLVE: the slice index k runs from 0 to NSLICE-1, one per cycle.
  - Each cycle computes nibble k of S+C with a 4-bit CLA, using the registered slice carry (0 for k=0).
  - It writes that nibble into the result register and registers the slice carry-out.
  - After slice NSLICE-1 the state goes to OUTPUT, and the final carry-out is discarded.
- Latency: if the last operand is accepted at edge E0, out_valid rises after edge E0+NSLICE (3 cycles for defaults). No operands are accepted between E0 and the output handshake.
- OUTPUT: out_valid=1, and out_sum, out_count and out_overflow are held stable until out_valid && out_ready. On that handshake edge: S, C, count, overflow and result clear to 0 and the state becomes IDLE; in_ready rises the following cycle. out_ready is ignored in other states.
- Outside OUTPUT, out_sum, out_count and out_overflow read 0.
- clear: has priority over all other events in any state. On the next edge, registers reset to their reset values and the state becomes IDLE. An operand presented in the same cycle is dropped. A result pending in OUTPUT is discarded without a handshake.
- Reset asserted mid-packet (any state): immediate return to reset values; nothing is retained.
- Single-operand packet (first beat has in_last=1) is legal; the result equals the operand.
- in_last is ignored unless the beat is accepted. A packet of zero operands cannot be formed.

Test Plan:
- Defaults; operands 0xFF,0xFF,0xFF (last on third) -> out_sum=0x2FD, out_count=3, out_overflow=0; out_valid 3 cycles after last acceptance.
- Single operand 0x5A with in_last=1 -> out_sum=0x05A, out_count=1; back-to-back next packet 0x01,0x02 -> 0x003.
- 16 operands of 0xFF -> out_sum=0xFF0, out_count=16, out_overflow=0; 17 operands of 0xFF -> out_sum=0x0EF (4335 mod 4096), out_count=16, out_overflow=1.
- Hold out_ready=0 for 5 cycles in OUTPUT -> outputs stable, in_ready=0, in_valid ignored; out_ready=1 -> IDLE next edge, outputs read 0.
- Assert clear during ACCUM with in_valid=1 after operands 0x10,0x20 -> IDLE, operand dropped; new packet 0x07 last -> out_sum=0x007, out_count=1.
- Drop rst_n asynchronously during RESOLVE slice 1 -> outputs immediately 0, busy=0, in_ready=1; a subsequent packet 0x80,0x80 -> 0x100.
